// File: rtl/except_sched.sv
// Exception/eret sequencer between the MEM stage, CP0 and pipeline control.
// Picks one event in IDLE, reports it to CP0 for a single cycle, then flushes.
module except_sched #(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic        mem_exc_valid_i,
    input  logic [4:0]  mem_exc_code_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o,
    output logic        drop_o,
    output logic [15:0] exc_count_o
);

    localparam int unsigned       CNT_W      = 4;
    localparam logic [CNT_W-1:0]  FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [4:0]        CODE_SYS   = 5'd8;
    localparam logic [4:0]        CODE_RI    = 5'd10;
    localparam logic [4:0]        CODE_OV    = 5'd12;
    localparam logic [4:0]        CODE_TRAP  = 5'd13;
    localparam logic [4:0]        CODE_ERET  = 5'd14;
    localparam logic [31:0]       TYPE_INT   = 32'd1;
    localparam logic [31:0]       TYPE_ERET  = 32'd14;

    typedef enum logic [1:0] {IDLE, COMMIT, FLUSH} state_t;

    state_t             state;
    logic [CNT_W-1:0]   flush_cnt;

    logic               int_pend_c;
    logic               int_take_c;
    logic               is_sync_c;
    logic               sync_take_c;
    logic               eret_take_c;
    logic               accept_c;
    logic               drop_c;
    logic [31:0]        event_code_c;
    logic               unused_bits;

    assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

    // Event selection: interrupt, then synchronous exception, then eret.
    always_comb begin
        int_pend_c   = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
        is_sync_c    = (mem_exc_code_i == CODE_SYS) || (mem_exc_code_i == CODE_RI) ||
                       (mem_exc_code_i == CODE_OV)  || (mem_exc_code_i == CODE_TRAP);
        int_take_c   = int_pend_c & mem_valid_i;
        sync_take_c  = mem_exc_valid_i & is_sync_c & ~status_i[1];
        eret_take_c  = mem_exc_valid_i & (mem_exc_code_i == CODE_ERET);
        accept_c     = int_take_c | sync_take_c | eret_take_c;
        drop_c       = ~int_take_c & mem_exc_valid_i & is_sync_c & status_i[1];
        event_code_c = 32'd0;
        if (int_take_c) begin
            event_code_c = TYPE_INT;
        end else if (sync_take_c || eret_take_c) begin
            event_code_c = 32'(mem_exc_code_i);
        end
    end

    // Sequencer with registered CP0 and pipeline-control outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= IDLE;
            flush_cnt           <= '0;
            excepttype_o        <= '0;
            current_inst_addr_o <= '0;
            is_in_delayslot_o   <= 1'b0;
            flush_o             <= 1'b0;
            new_pc_o            <= '0;
            busy_o              <= 1'b0;
            drop_o              <= 1'b0;
            exc_count_o         <= '0;
        end else begin
            drop_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state               <= COMMIT;
                        excepttype_o        <= event_code_c;
                        current_inst_addr_o <= mem_pc_i;
                        is_in_delayslot_o   <= mem_in_delayslot_i;
                        busy_o              <= 1'b1;
                        if (exc_count_o != 16'hFFFF) begin
                            exc_count_o <= exc_count_o + 16'd1;
                        end
                    end else begin
                        drop_o <= drop_c;
                    end
                end
                COMMIT: begin
                    // CP0 latches excepttype_o on this edge; flush starts right after.
                    excepttype_o <= '0;
                    new_pc_o     <= (excepttype_o == TYPE_ERET) ? epc_i : EXC_VECTOR;
                    flush_o      <= 1'b1;
                    flush_cnt    <= FLUSH_LOAD;
                    state        <= FLUSH;
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        state    <= IDLE;
                        flush_o  <= 1'b0;
                        new_pc_o <= '0;
                        busy_o   <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_except_sched.sv
// Self-checking bench for except_sched: directed scenarios plus randomized
// events checked against a rule-level reference model.
module tb_except_sched;

    localparam logic [31:0] VEC = 32'h0000_0020;
    localparam int          FC  = 2;
    localparam int          DROP_EV = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_exc_valid = 1'b0;
    logic [4:0]  mem_exc_code = '0;
    logic [31:0] mem_pc = '0;
    logic        mem_ds = 1'b0;
    logic [31:0] status = '0;
    logic [31:0] cause = '0;
    logic [31:0] epc = '0;
    logic [31:0] excepttype_o;
    logic [31:0] current_inst_addr_o;
    logic        is_in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;
    logic        drop_o;
    logic [15:0] exc_count_o;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_count = '0;

    typedef struct packed {
        logic [31:0] et;
        logic        fl;
        logic [31:0] pc;
        logic        busy;
        logic        drop;
    } obs_t;

    except_sched #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid), .mem_exc_valid_i(mem_exc_valid),
        .mem_exc_code_i(mem_exc_code), .mem_pc_i(mem_pc),
        .mem_in_delayslot_i(mem_ds), .status_i(status), .cause_i(cause),
        .epc_i(epc), .excepttype_o(excepttype_o),
        .current_inst_addr_o(current_inst_addr_o),
        .is_in_delayslot_o(is_in_delayslot_o), .flush_o(flush_o),
        .new_pc_o(new_pc_o), .busy_o(busy_o), .drop_o(drop_o),
        .exc_count_o(exc_count_o)
    );

    always #5 clk = ~clk;

    function automatic obs_t obs();
        obs_t o;
        o.et = excepttype_o; o.fl = flush_o; o.pc = new_pc_o;
        o.busy = busy_o; o.drop = drop_o;
        return o;
    endfunction

    function automatic obs_t mk(logic [31:0] et, logic fl, logic [31:0] pc, logic busy, logic drop);
        obs_t o;
        o.et = et; o.fl = fl; o.pc = pc; o.busy = busy; o.drop = drop;
        return o;
    endfunction

    // Reference rules: which event (if any) the block reports for one IDLE sample.
    function automatic int model_event(logic v, logic ev, logic [4:0] code,
                                       logic [31:0] st, logic [31:0] ca);
        bit ie = st[0];
        bit exl = st[1];
        bit pend = ((ca[15:8] & st[15:8]) != 8'h00);
        bit sync = (code == 8) || (code == 10) || (code == 12) || (code == 13);
        if (ie && !exl && pend && v) return 1;
        if (ev && sync && !exl) return int'(code);
        if (ev && code == 14) return 14;
        if (ev && sync && exl) return DROP_EV;
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        mem_valid = 0; mem_exc_valid = 0; mem_exc_code = '0;
        mem_pc = '0; mem_ds = 0; status = '0; cause = '0;
    endtask

    task automatic count_up();
        if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    endtask

    task automatic test_reset();
        obs_t got;
        clear_inputs();
        rst = 0;
        #12;
        got = obs();
        total++;
        if (got !== mk(0, 0, 0, 0, 0) || exc_count_o !== 16'h0 || current_inst_addr_o !== 32'h0
            || is_in_delayslot_o !== 1'b0) begin
            bad++;
            $display("FAIL reset got=%h cnt=%h addr=%h", got, exc_count_o, current_inst_addr_o);
        end
        @(negedge clk);
        rst = 1;
        step();
    endtask

    task automatic test_syscall();
        obs_t got;
        status = 32'h1000_0000; mem_valid = 1; mem_exc_valid = 1;
        mem_exc_code = 5'd8; mem_pc = 32'h100; mem_ds = 1;
        step();
        clear_inputs();
        count_up();
        got = obs();
        total++;
        if (got !== mk(32'h8, 0, 0, 1, 0) || current_inst_addr_o !== 32'h100
            || is_in_delayslot_o !== 1'b1 || exc_count_o !== exp_count) begin
            bad++;
            $display("FAIL syscall_commit got=%h addr=%h ds=%b cnt=%h exp_cnt=%h",
                     got, current_inst_addr_o, is_in_delayslot_o, exc_count_o, exp_count);
        end
        for (int k = 1; k <= FC; k++) begin
            step();
            got = obs();
            total++;
            if (got !== mk(0, 1, VEC, 1, 0)) begin
                bad++;
                $display("FAIL syscall_flush%0d got=%h exp=%h", k, got, mk(0, 1, VEC, 1, 0));
            end
        end
        step();
        got = obs();
        total++;
        if (got !== mk(0, 0, 0, 0, 0) || exc_count_o !== 16'd1) begin
            bad++;
            $display("FAIL syscall_done got=%h cnt=%h exp_cnt=1", got, exc_count_o);
        end
    endtask

    task automatic test_int_vs_exc();
        obs_t got;
        status = 32'h1000_0401; cause = 32'h0000_0400; mem_valid = 1;
        mem_exc_valid = 1; mem_exc_code = 5'd12; mem_pc = 32'h200;
        step();
        clear_inputs();
        count_up();
        got = obs();
        total++;
        if (got !== mk(32'h1, 0, 0, 1, 0) || current_inst_addr_o !== 32'h200) begin
            bad++;
            $display("FAIL int_commit got=%h addr=%h exp=%h", got, current_inst_addr_o, mk(1, 0, 0, 1, 0));
        end
        for (int k = 1; k <= FC; k++) begin
            step();
            got = obs();
            total++;
            if (got !== mk(0, 1, VEC, 1, 0)) begin
                bad++;
                $display("FAIL int_flush%0d got=%h exp=%h", k, got, mk(0, 1, VEC, 1, 0));
            end
        end
        step();
        got = obs();
        total++;
        if (got !== mk(0, 0, 0, 0, 0) || exc_count_o !== exp_count) begin
            bad++;
            $display("FAIL int_done got=%h cnt=%h exp_cnt=%h", got, exc_count_o, exp_count);
        end
    endtask

    task automatic test_eret();
        obs_t got;
        status = 32'h1000_0002; epc = 32'h400; mem_valid = 1;
        mem_exc_valid = 1; mem_exc_code = 5'd14; mem_pc = 32'h300;
        step();
        clear_inputs();
        count_up();
        got = obs();
        total++;
        if (got !== mk(32'hE, 0, 0, 1, 0)) begin
            bad++;
            $display("FAIL eret_commit got=%h exp=%h", got, mk(32'hE, 0, 0, 1, 0));
        end
        for (int k = 1; k <= FC; k++) begin
            step();
            got = obs();
            total++;
            if (got !== mk(0, 1, 32'h400, 1, 0)) begin
                bad++;
                $display("FAIL eret_flush%0d got=%h exp=%h", k, got, mk(0, 1, 32'h400, 1, 0));
            end
        end
        step();
        got = obs();
        total++;
        if (got !== mk(0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL eret_done got=%h exp=0", got);
        end
    endtask

    task automatic test_drop();
        obs_t got;
        status = 32'h1000_0002; mem_valid = 1; mem_exc_valid = 1;
        mem_exc_code = 5'd10; mem_pc = 32'h500;
        step();
        clear_inputs();
        got = obs();
        total++;
        if (got !== mk(0, 0, 0, 0, 1) || exc_count_o !== exp_count) begin
            bad++;
            $display("FAIL drop_pulse got=%h cnt=%h exp_cnt=%h", got, exc_count_o, exp_count);
        end
        step();
        got = obs();
        total++;
        if (got !== mk(0, 0, 0, 0, 0)) begin
            bad++;
            $display("FAIL drop_clear got=%h exp=0", got);
        end
    endtask

    task automatic test_reset_mid_flush();
        obs_t got;
        status = 32'h1000_0000; mem_exc_valid = 1; mem_exc_code = 5'd8; mem_pc = 32'h600;
        step();
        clear_inputs();
        step();
        rst = 0;
        #1;
        got = obs();
        total++;
        if (got !== mk(0, 0, 0, 0, 0) || exc_count_o !== 16'h0) begin
            bad++;
            $display("FAIL reset_mid_flush got=%h cnt=%h exp=0", got, exc_count_o);
        end
        exp_count = '0;
        step();
        rst = 1;
        step();
        status = 32'h1000_0000; mem_exc_valid = 1; mem_exc_code = 5'd8; mem_pc = 32'h700;
        step();
        clear_inputs();
        count_up();
        got = obs();
        total++;
        if (got !== mk(32'h8, 0, 0, 1, 0) || current_inst_addr_o !== 32'h700 || exc_count_o !== 16'd1) begin
            bad++;
            $display("FAIL after_reset_commit got=%h addr=%h cnt=%h", got, current_inst_addr_o, exc_count_o);
        end
        for (int k = 0; k <= FC; k++) step();
    endtask

    task automatic test_random();
        obs_t got;
        obs_t exp;
        logic [4:0] codes [8] = '{5'd8, 5'd10, 5'd12, 5'd13, 5'd14, 5'd9, 5'd0, 5'd31};
        int ev;
        logic [31:0] e_pc;
        logic e_ds;
        logic [31:0] e_target;
        for (int it = 0; it < 300; it++) begin
            mem_valid = 1'($urandom);
            mem_exc_valid = 1'($urandom);
            mem_exc_code = codes[$urandom_range(0, 7)];
            mem_pc = $urandom;
            mem_ds = 1'($urandom);
            status = $urandom & 32'h0000_FF03;
            cause = ($urandom & $urandom) & 32'h0000_FF00;
            epc = $urandom;
            ev = model_event(mem_valid, mem_exc_valid, mem_exc_code, status, cause);
            e_pc = mem_pc;
            e_ds = mem_ds;
            e_target = (ev == 14) ? epc : VEC;
            step();
            got = obs();
            if (ev == DROP_EV) exp = mk(0, 0, 0, 0, 1);
            else if (ev == 0) exp = mk(0, 0, 0, 0, 0);
            else begin
                exp = mk(32'(ev), 0, 0, 1, 0);
                count_up();
            end
            total++;
            if (got !== exp || exc_count_o !== exp_count
                || (ev != 0 && ev != DROP_EV && (current_inst_addr_o !== e_pc || is_in_delayslot_o !== e_ds))) begin
                bad++;
                $display("FAIL rand_sample it=%0d got=%h exp=%h cnt=%h exp_cnt=%h addr=%h exp_addr=%h",
                         it, got, exp, exc_count_o, exp_count, current_inst_addr_o, e_pc);
            end
            if (ev != 0 && ev != DROP_EV) begin
                for (int k = 1; k <= FC + 1; k++) begin
                    mem_valid = 1'($urandom); mem_exc_valid = 1'($urandom);
                    mem_exc_code = codes[$urandom_range(0, 7)]; mem_pc = $urandom;
                    status = $urandom & 32'h0000_FF03; cause = $urandom & 32'h0000_FF00;
                    step();
                    got = obs();
                    exp = (k <= FC) ? mk(0, 1, e_target, 1, 0) : mk(0, 0, 0, 0, 0);
                    total++;
                    if (got !== exp || exc_count_o !== exp_count) begin
                        bad++;
                        $display("FAIL rand_flush it=%0d k=%0d got=%h exp=%h cnt=%h", it, k, got, exp, exc_count_o);
                    end
                end
            end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_busy_mask_sat();
        obs_t got;
        status = 32'h1000_0000; mem_exc_valid = 1; mem_exc_code = 5'd8; mem_pc = 32'h800;
        step();
        count_up();
        mem_exc_code = 5'd13; mem_pc = 32'h900;
        for (int k = 0; k <= FC; k++) step();
        clear_inputs();
        got = obs();
        total++;
        if (got !== mk(0, 0, 0, 0, 0) || exc_count_o !== exp_count) begin
            bad++;
            $display("FAIL busy_mask got=%h cnt=%h exp_cnt=%h", got, exc_count_o, exp_count);
        end
        force dut.exc_count_o = 16'hFFFE;
        #1;
        release dut.exc_count_o;
        exp_count = 16'hFFFE;
        for (int n = 0; n < 2; n++) begin
            status = 32'h1000_0000; mem_exc_valid = 1; mem_exc_code = 5'd13; mem_pc = 32'hA00;
            step();
            clear_inputs();
            count_up();
            total++;
            if (exc_count_o !== exp_count || excepttype_o !== 32'hD) begin
                bad++;
                $display("FAIL saturate%0d cnt=%h exp_cnt=%h et=%h", n, exc_count_o, exp_count, excepttype_o);
            end
            for (int k = 0; k <= FC; k++) step();
        end
    endtask

    initial begin
        test_reset();
        test_syscall();
        test_int_vs_exc();
        test_eret();
        test_drop();
        test_reset_mid_flush();
        test_random();
        test_busy_mask_sat();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
